// File: rtl/line_pkg.sv
// Shared types and constants for the Bresenham line drawer.
package line_pkg;

  localparam int unsigned COORD_W_DEFAULT = 10;
  localparam int unsigned COLOR_W_DEFAULT = 4;

  // Visible frame-buffer size, used when clipping is compiled in.
  localparam int unsigned FB_WIDTH  = 640;
  localparam int unsigned FB_HEIGHT = 480;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StDraw
  } state_e;

endpackage

// File: rtl/line_drawer_if.sv
// Request/response and frame-buffer write bundle for line_drawer.
// master: initiator side; slave: the drawer.
interface line_drawer_if
  import line_pkg::*;
#(
  parameter int unsigned COORD_W = COORD_W_DEFAULT,
  parameter int unsigned COLOR_W = COLOR_W_DEFAULT
) ();

  logic               start;
  logic [COORD_W-1:0] x0;
  logic [COORD_W-1:0] y0;
  logic [COORD_W-1:0] x1;
  logic [COORD_W-1:0] y1;
  logic [COLOR_W-1:0] color;
  logic [COORD_W-1:0] fb_x;
  logic [COORD_W-1:0] fb_y;
  logic [COLOR_W-1:0] data;
  logic               fb_we;
  logic               busy;
  logic               done;

  modport master (
    output start, x0, y0, x1, y1, color,
    input  fb_x, fb_y, data, fb_we, busy, done
  );

  modport slave (
    input  start, x0, y0, x1, y1, color,
    output fb_x, fb_y, data, fb_we, busy, done
  );

endinterface

// File: rtl/line_step.sv
// One combinational Bresenham step: next err/x/y from the current point.
module line_step
  import line_pkg::*;
#(
  parameter int unsigned COORD_W = COORD_W_DEFAULT
) (
  input  logic signed [COORD_W+1:0] err_i,
  input  logic        [COORD_W:0]   dx_i,
  input  logic signed [COORD_W+1:0] dy_i,
  input  logic                      sx_neg_i,
  input  logic                      sy_neg_i,
  input  logic        [COORD_W-1:0] x_i,
  input  logic        [COORD_W-1:0] y_i,
  output logic signed [COORD_W+1:0] err_o,
  output logic        [COORD_W-1:0] x_o,
  output logic        [COORD_W-1:0] y_o
);

  localparam logic [COORD_W-1:0] One = 1;

  logic signed [COORD_W+2:0] e2;
  logic signed [COORD_W+2:0] dx_s;
  logic signed [COORD_W+2:0] dy_s;
  logic signed [COORD_W+2:0] err_acc;

  // Both axis updates test the same e2, so they may fire together.
  always_comb begin
    e2      = {err_i, 1'b0};
    dx_s    = {2'b00, dx_i};
    dy_s    = {dy_i[COORD_W+1], dy_i};
    err_acc = {err_i[COORD_W+1], err_i};
    x_o     = x_i;
    y_o     = y_i;
    if (e2 >= dy_s) begin
      err_acc = err_acc + dy_s;
      x_o     = sx_neg_i ? (x_i - One) : (x_i + One);
    end
    if (e2 <= dx_s) begin
      err_acc = err_acc + dx_s;
      y_o     = sy_neg_i ? (y_i - One) : (y_i + One);
    end
    err_o = err_acc[COORD_W+1:0];
  end

endmodule

// File: rtl/line_drawer.sv
// Bresenham line drawer: one line per start rising edge, one pixel per cycle.
// Optional LINE_DRAWER_CLIP_EN suppresses writes outside the 640x480 frame.
module line_drawer
  import line_pkg::*;
#(
  parameter int unsigned COORD_W = COORD_W_DEFAULT,
  parameter int unsigned COLOR_W = COLOR_W_DEFAULT
) (
  input logic          clk,
  input logic          areset,
  line_drawer_if.slave bus
);

  state_e                    state_q;
  logic                      start_q;
  logic                      busy_q;
  logic                      done_q;
  logic        [COORD_W-1:0] x_q, y_q, x1_q, y1_q;
  logic        [COLOR_W-1:0] color_q;
  logic        [COORD_W:0]   dx_q;
  logic signed [COORD_W+1:0] dy_q;
  logic signed [COORD_W+1:0] err_q;
  logic                      sx_neg_q, sy_neg_q;
  logic        [COORD_W-1:0] fb_x_q, fb_y_q;
  logic        [COLOR_W-1:0] data_q;
  logic                      fb_we_q;

  logic        [COORD_W:0]   dx_c;
  logic signed [COORD_W+1:0] dy_c;
  logic signed [COORD_W+1:0] err_n;
  logic        [COORD_W-1:0] x_n, y_n;
  logic                      pix_vis;

  // Setup-phase deltas from the latched endpoints.
  always_comb begin
    dx_c = {1'b0, (x1_q >= x_q) ? (x1_q - x_q) : (x_q - x1_q)};
    dy_c = -$signed({2'b00, (y1_q >= y_q) ? (y1_q - y_q) : (y_q - y1_q)});
  end

`ifdef LINE_DRAWER_CLIP_EN
  assign pix_vis = (32'(x_q) < FB_WIDTH) && (32'(y_q) < FB_HEIGHT);
`else
  assign pix_vis = 1'b1;
`endif

  line_step #(
    .COORD_W (COORD_W)
  ) u_step (
    .err_i    (err_q),
    .dx_i     (dx_q),
    .dy_i     (dy_q),
    .sx_neg_i (sx_neg_q),
    .sy_neg_i (sy_neg_q),
    .x_i      (x_q),
    .y_i      (y_q),
    .err_o    (err_n),
    .x_o      (x_n),
    .y_o      (y_n)
  );

  // Control FSM with registered frame-buffer outputs. busy_q still set while
  // back in idle marks the done cycle.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q  <= StIdle;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      color_q  <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
      fb_x_q   <= '0;
      fb_y_q   <= '0;
      data_q   <= '0;
      fb_we_q  <= 1'b0;
    end else begin
      start_q <= bus.start;
      done_q  <= 1'b0;
      fb_we_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (busy_q) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else if (bus.start && !start_q) begin
            state_q <= StSetup;
            busy_q  <= 1'b1;
            x_q     <= bus.x0;
            y_q     <= bus.y0;
            x1_q    <= bus.x1;
            y1_q    <= bus.y1;
            color_q <= bus.color;
          end
        end
        StSetup: begin
          dx_q     <= dx_c;
          dy_q     <= dy_c;
          err_q    <= $signed({1'b0, dx_c}) + dy_c;
          sx_neg_q <= (x1_q < x_q);
          sy_neg_q <= (y1_q < y_q);
          state_q  <= StDraw;
        end
        StDraw: begin
          if (pix_vis) begin
            fb_x_q  <= x_q;
            fb_y_q  <= y_q;
            data_q  <= color_q;
            fb_we_q <= 1'b1;
          end
          if ((x_q == x1_q) && (y_q == y1_q)) begin
            state_q <= StIdle;
          end else begin
            x_q   <= x_n;
            y_q   <= y_n;
            err_q <= err_n;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.fb_x  = fb_x_q;
  assign bus.fb_y  = fb_y_q;
  assign bus.data  = data_q;
  assign bus.fb_we = fb_we_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_line_drawer.sv
// Self-checking bench for line_drawer: directed and random lines against a
// plain-integer Bresenham reference.
module tb_line_drawer;
  import line_pkg::*;

  localparam int unsigned CW = COORD_W_DEFAULT;
  localparam int unsigned LW = COLOR_W_DEFAULT;

  logic clk    = 1'b0;
  logic areset = 1'b1;

  line_drawer_if #(.COORD_W(CW), .COLOR_W(LW)) bus ();

  line_drawer #(
    .COORD_W (CW),
    .COLOR_W (LW)
  ) dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int x;
    int y;
  } pix_t;

  pix_t exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic bit visible(input int x, input int y);
`ifdef LINE_DRAWER_CLIP_EN
    return (x < int'(FB_WIDTH)) && (y < int'(FB_HEIGHT));
`else
    return 1'b1;
`endif
  endfunction

  // Classic integer Bresenham walk, all octants.
  task automatic build_ref(input int x0, input int y0, input int x1, input int y1);
    int dx, dy, sx, sy, err, e2, x, y;
    exp_q.delete();
    dx  = iabs(x1 - x0);
    dy  = -iabs(y1 - y0);
    sx  = (x1 < x0) ? -1 : 1;
    sy  = (y1 < y0) ? -1 : 1;
    err = dx + dy;
    x   = x0;
    y   = y0;
    for (int k = 0; k < 4096; k++) begin
      exp_q.push_back('{x: x, y: y});
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  // Draw one line; start stays high for 'hold' cycles after the accept edge
  // (or through done if longer). 'glitch' re-pulses start while busy.
  task automatic draw(input int x0, input int y0, input int x1, input int y1, input int c,
                      input int hold, input bit glitch, input string tag, output int nwe);
    int  n;
    int  nvis;
    bit  we_exp;
    build_ref(x0, y0, x1, y1);
    n    = exp_q.size();
    nvis = 0;
    nwe  = 0;
    foreach (exp_q[i]) if (visible(exp_q[i].x, exp_q[i].y)) nvis++;
    @(negedge clk);
    bus.x0    = x0[CW-1:0];
    bus.y0    = y0[CW-1:0];
    bus.x1    = x1[CW-1:0];
    bus.y1    = y1[CW-1:0];
    bus.color = c[LW-1:0];
    bus.start = 1'b1;
    areset    = 1'b0;
    @(posedge clk);
    for (int j = 0; j <= n + 2; j++) begin
      @(negedge clk);
      if (j + 1 == hold) bus.start = 1'b0;
      if (glitch && j == 3) bus.start = 1'b0;
      if (glitch && j == 4) bus.start = 1'b1;
      if (bus.fb_we === 1'b1) nwe++;
      if (j >= 2 && j < n + 2) begin
        we_exp = visible(exp_q[j-2].x, exp_q[j-2].y);
        check_eq({tag, " we"}, bus.fb_we, we_exp);
        if (we_exp) begin
          check_eq({tag, " x"}, bus.fb_x, exp_q[j-2].x);
          check_eq({tag, " y"}, bus.fb_y, exp_q[j-2].y);
          check_eq({tag, " data"}, bus.data, c);
        end
      end else begin
        check_eq({tag, " we idle"}, bus.fb_we, 0);
      end
      check_eq({tag, " done"}, bus.done, (j == n + 2) ? 1 : 0);
      check_eq({tag, " busy"}, bus.busy, (j < n + 2) ? 1 : 0);
    end
    @(negedge clk);
    check_eq({tag, " done width"}, bus.done, 0);
    // Start may still be high here: no retrigger allowed.
    repeat (3) begin
      @(negedge clk);
      check_eq({tag, " no retrigger"}, bus.busy, 0);
      check_eq({tag, " no retrigger we"}, bus.fb_we, 0);
    end
    bus.start = 1'b0;
    check_eq({tag, " we count"}, nwe, nvis);
  endtask

  initial begin
    int nwe;
    int x0, y0, x1, y1;
    bus.start = 1'b0;
    bus.x0    = '0;
    bus.y0    = '0;
    bus.x1    = '0;
    bus.y1    = '0;
    bus.color = '0;

    repeat (2) @(negedge clk);
    check_eq("rst fb_we", bus.fb_we, 0);
    check_eq("rst busy", bus.busy, 0);
    check_eq("rst done", bus.done, 0);
    check_eq("rst fb_x", bus.fb_x, 0);
    check_eq("rst fb_y", bus.fb_y, 0);
    check_eq("rst data", bus.data, 0);

    // Start already high at reset release counts as an edge.
    draw(10, 20, 15, 20, 'hA, 1, 1'b0, "horiz", nwe);
    check_eq("horiz count", nwe, 6);
    draw(15, 5, 10, 5, 'h3, 1, 1'b0, "reverse", nwe);
    check_eq("reverse count", nwe, 6);
    draw(0, 0, 2, 5, 'h5, 1, 1'b0, "steep", nwe);
    check_eq("steep count", nwe, 6);
    draw(7, 7, 7, 7, 'h9, 1, 1'b0, "point", nwe);
    check_eq("point count", nwe, 1);

    // Held start, then a second request shortly after done.
    draw(1, 1, 3, 2, 'h6, 4, 1'b0, "hold4 a", nwe);
    draw(3, 2, 1, 1, 'h7, 4, 1'b0, "hold4 b", nwe);
    // Start held through done and re-pulsed while busy.
    draw(20, 3, 4, 9, 'hC, 1000, 1'b1, "held glitch", nwe);

    // Reset mid-line, then a full line with start high across release.
    @(negedge clk);
    bus.x0    = '0;
    bus.y0    = '0;
    bus.x1    = 10'd100;
    bus.y1    = 10'd30;
    bus.color = 4'hF;
    bus.start = 1'b1;
    repeat (8) @(negedge clk);
    areset = 1'b1;
    #1;
    check_eq("midrst fb_we", bus.fb_we, 0);
    check_eq("midrst busy", bus.busy, 0);
    check_eq("midrst fb_x", bus.fb_x, 0);
    check_eq("midrst fb_y", bus.fb_y, 0);
    check_eq("midrst data", bus.data, 0);
    @(negedge clk);
    check_eq("midrst hold we", bus.fb_we, 0);
    check_eq("midrst hold done", bus.done, 0);
    draw(5, 40, 60, 2, 'h2, 1, 1'b0, "after rst", nwe);

    draw(630, 0, 645, 0, 'h1, 1, 1'b0, "clip", nwe);
`ifdef LINE_DRAWER_CLIP_EN
    check_eq("clip count", nwe, 10);
`else
    check_eq("clip count", nwe, 16);
`endif

    for (int t = 0; t < 20; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        x0 = $urandom_range(0, 1023);
        y0 = $urandom_range(0, 1023);
        x1 = $urandom_range(0, 1023);
        y1 = $urandom_range(0, 1023);
      end else begin
        x0 = $urandom_range(600, 680);
        y0 = $urandom_range(440, 520);
        x1 = x0 + $urandom_range(0, 60) - 30;
        y1 = y0 + $urandom_range(0, 60) - 30;
      end
      draw(x0, y0, x1, y1, $urandom_range(0, 15), $urandom_range(1, 6), 1'b0, "random", nwe);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
